led_chaser: RTL and testbench
=============================

Name: led_chaser

Overview:
- Parametrised LED pattern generator: the next generation of the single-pattern rotating light on the nvboard LED bank.
- Drives N_LED LEDs, stepping a pattern register every STEP_CYCLES clocks (divisible by a runtime speed select).
- Four motion modes: rotate left, rotate right, bounce, fill/drain bar.
- Supports pattern load, pause, and a PWM brightness gate on the LED outputs.

Parameters:
- N_LED, 16, number of LEDs / pattern width; must be >= 2.
- STEP_CYCLES, 5000000, base step period in clocks (0.5 s at 10 MHz); must be >= 1.
- PWM_BITS, 8, width of the brightness input and of the PWM counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  1 = step counter and pattern advance; 0 = freeze both.
- mode  in  2  00 ROL, 01 ROR, 10 BOUNCE, 11 FILL.
- speed  in  2  step period P = STEP_CYCLES >> speed; P = 1 if the shift gives 0.
- load  in  1  synchronous pattern load strobe.
- load_pattern  in  N_LED  value written on load.
- brightness  in  PWM_BITS  PWM duty.
- led  out  N_LED  registered, PWM-gated pattern.
- pattern  out  N_LED  current unmodulated pattern register.
- step_pulse  out  1  high for exactly the cycle in which a new pattern value appears on pattern.

Behaviour:
- Reset (async, immediate, also mid-step):
  - pattern = 1 (bit 0 set); led = 0; step_pulse = 0.
  - step counter = 0; pwm counter = 0; dir = left; fill = 1.
- Step counter:
  - With en=1, counts 0..P-1. At count==P-1 a step occurs and the count returns to 0.
  - First step lands P cycles after reset release with en held 1.
  - en=0 holds the count and pattern. A speed change takes effect on the next compare; if count >= the new P-1, the step fires on the next cycle.
- On a step, pattern updates per the mode sampled in that cycle. dir and fill flags persist across mode changes.
  - ROL: {p[N-2:0], p[N-1]}.
  - ROR: {p[0], p[N-1:1]}.
  - BOUNCE, dir=left: if p[N-1]=1, set dir=right and apply ROR; else apply ROL.
  - BOUNCE, dir=right: if p[0]=1, set dir=left and apply ROL; else apply ROR.
  - BOUNCE with a zero pattern keeps shifting zeros.
  - FILL, fill=1: if p is all ones, clear fill and shift in 0; else shift left, inserting 1.
  - FILL, fill=0: if p is all zero, set fill and shift in 1; else shift left, inserting 0.
  - FILL cycle length is 2*N_LED steps.
- step_pulse: registered, high for one cycle together with the pattern update; never high when en=0 or on a load.
- load (sync, highest priority after rst):
  - pattern <= load_pattern; counter <= 0; dir <= left; fill <= 1.
  - A coincident step is discarded; the next step lands P cycles later.
- PWM:
  - Free-running counter 0..2^PWM_BITS-1, wraps; runs regardless of en and load.
  - on = (brightness == all ones) or (pwm_cnt < brightness).
  - brightness 0 gives led always 0; all-ones gives led always equal to pattern.
- Output timing: led <= on ? pattern : 0, one-cycle latency behind pattern and the pwm counter.
- Widths: step counter is clog2(STEP_CYCLES+1) bits; no overflow is possible. mode/speed/brightness need no synchroniser; they are assumed synchronous to clk.

Test Plan (N_LED=8, STEP_CYCLES=4, PWM_BITS=2, brightness=3 unless stated):
1. ROL: release rst, en=1, mode=00, speed=0 -> pattern 0x01, step_pulse at cycles 4, 8, 12…; pattern 0x02, 0x04, …, 0x80, back to 0x01 after 8 steps; led equals pattern delayed 1 cycle. ROR mirrors this: 0x80, 0x40, ….
2. Speed: speed=1 -> step every 2 cycles; speed=2 and speed=3 (4>>3=0 -> P=1) -> step every cycle, step_pulse held high continuously.
3. BOUNCE from 0x01 -> 0x80 at step 7, 0x40 at step 8, 0x01 at step 14, 0x02 at step 15; switching to ROL mid-bounce rotates left from the current value.
4. FILL from 0x01 -> 0x03, 0x07, …, 0xFF at step 7; 0xFE at step 8, …, 0x00 at step 15; 0x01 at step 16.
5. Load/pause: load=1 with load_pattern=0xA5 while count=3 -> pattern 0xA5, no step_pulse, next step 4 cycles later gives 0x4B; en=0 for 10 cycles -> pattern and count frozen, no step_pulse.
6. PWM/reset:
   - brightness=1 -> led=pattern 1 cycle in 4; brightness=0 -> led=0; brightness=3 -> led continuous.
   - Assert rst between clock edges mid-count -> led=0 and pattern=0x01 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/led_chaser.sv
// led_chaser: parametrised LED pattern generator.
// A pattern register advances once per step period (base period divided by a
// runtime speed select) in one of four motions: rotate left, rotate right,
// bounce, or fill/drain bar. The LED outputs show the pattern, registered and
// gated by a free-running PWM brightness comparator.
//
// Handshake note: there is no valid/ready interface here. load is a
// single-cycle strobe that is always accepted, and step_pulse is an
// unconditional one-cycle marker that qualifies the new value on pattern.
`timescale 1ns/1ps
module led_chaser #(
  parameter int N_LED       = 16,
  parameter int STEP_CYCLES = 5000000,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [1:0]          speed,
  input  logic                load,
  input  logic [N_LED-1:0]    load_pattern,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LED-1:0]    led,
  output logic [N_LED-1:0]    pattern,
  output logic                step_pulse
);

  localparam int CNT_W = $clog2(STEP_CYCLES + 1);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_t;

  // Bounce direction flag; persists across mode changes.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  mode_t                mode_sel;
  dir_t                 dir_q, dir_d;
  logic                 fill_q, fill_d;
  logic [CNT_W-1:0]     step_cnt;
  logic [CNT_W-1:0]     period_raw;
  logic [CNT_W-1:0]     period_m1;
  logic                 step_hit;
  logic [N_LED-1:0]     pattern_d;
  logic [N_LED-1:0]     rol_val;
  logic [N_LED-1:0]     ror_val;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic                 pwm_on;

  // Step period selection; a shift that underflows to zero means "every cycle".
  always_comb begin
    mode_sel   = mode_t'(mode);
    period_raw = STEP_C >> speed;
    period_m1  = (period_raw == '0) ? '0 : (period_raw - CNT_ONE);
    // >= rather than == so that shortening the period mid-count steps at once.
    step_hit   = en && (step_cnt >= period_m1);
  end

  // Step counter: counts 0..P-1 while enabled, cleared by load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (load) begin
      step_cnt <= '0;
    end else if (en) begin
      if (step_hit) step_cnt <= '0;
      else          step_cnt <= step_cnt + CNT_ONE;
    end
  end

  // Next pattern and direction/fill flags for the mode sampled this cycle.
  always_comb begin
    rol_val   = {pattern[N_LED-2:0], pattern[N_LED-1]};
    ror_val   = {pattern[0], pattern[N_LED-1:1]};
    pattern_d = pattern;
    dir_d     = dir_q;
    fill_d    = fill_q;
    case (mode_sel)
      MODE_ROL: pattern_d = rol_val;
      MODE_ROR: pattern_d = ror_val;
      MODE_BOUNCE: begin
        if (dir_q == DIR_LEFT) begin
          if (pattern[N_LED-1]) begin
            dir_d     = DIR_RIGHT;
            pattern_d = ror_val;
          end else begin
            pattern_d = rol_val;
          end
        end else begin
          if (pattern[0]) begin
            dir_d     = DIR_LEFT;
            pattern_d = rol_val;
          end else begin
            pattern_d = ror_val;
          end
        end
      end
      MODE_FILL: begin
        if (fill_q) begin
          if (&pattern) begin
            fill_d    = 1'b0;
            pattern_d = {pattern[N_LED-2:0], 1'b0};
          end else begin
            pattern_d = {pattern[N_LED-2:0], 1'b1};
          end
        end else begin
          if (pattern == '0) begin
            fill_d    = 1'b1;
            pattern_d = {pattern[N_LED-2:0], 1'b1};
          end else begin
            pattern_d = {pattern[N_LED-2:0], 1'b0};
          end
        end
      end
      default: pattern_d = pattern;
    endcase
  end

  // Pattern register, flags and step marker; load wins over a coincident step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern    <= {{(N_LED-1){1'b0}}, 1'b1};
      dir_q      <= DIR_LEFT;
      fill_q     <= 1'b1;
      step_pulse <= 1'b0;
    end else if (load) begin
      pattern    <= load_pattern;
      dir_q      <= DIR_LEFT;
      fill_q     <= 1'b1;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= step_hit;
      if (step_hit) begin
        pattern <= pattern_d;
        dir_q   <= dir_d;
        fill_q  <= fill_d;
      end
    end
  end

  // Free-running PWM counter, independent of en and load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // Full-scale brightness is always on so the LEDs never blink at maximum.
  always_comb begin
    pwm_on = (&brightness) || (pwm_cnt < brightness);
  end

  // Registered, PWM-gated LED outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= '0;
    else     led <= pwm_on ? pattern : '0;
  end

endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: directed bench for led_chaser (N_LED=8, STEP_CYCLES=4,
// PWM_BITS=2). Expected patterns are queued when a phase is set up and
// popped whenever the DUT flags a step.
`timescale 1ns/1ps
module tb_led_chaser;

  localparam int N  = 8;
  localparam int SC = 4;
  localparam int PB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [1:0]    speed;
  logic          load;
  logic [N-1:0]  load_pattern;
  logic [PB-1:0] brightness;
  logic [N-1:0]  led;
  logic [N-1:0]  pattern;
  logic          step_pulse;

  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  cur;
  logic          check_led;
  int            total = 0;
  int            bad = 0;

  led_chaser #(.N_LED(N), .STEP_CYCLES(SC), .PWM_BITS(PB)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
    .load(load), .load_pattern(load_pattern), .brightness(brightness),
    .led(led), .pattern(pattern), .step_pulse(step_pulse)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick and, when enabled, check led against the bench's previous pattern.
  task automatic tick_led(input string tag);
    tick();
    if (check_led) chk({tag, "_led"}, led, cur);
  endtask

  // Wait for n steps, each expected exactly 'period' cycles after the last.
  task automatic run_steps(input int n, input int period, input string tag);
    logic [N-1:0] e;
    int c;
    for (int i = 0; i < n; i++) begin
      c = 0;
      do begin
        tick_led(tag);
        c++;
      end while (step_pulse !== 1'b1 && c < period + 4);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk({tag, "_period"}, c, period);
      chk({tag, "_pattern"}, pattern, e);
      cur = e;
    end
  endtask

  task automatic do_load(input logic [N-1:0] v, input string tag);
    load = 1'b1;
    load_pattern = v;
    tick_led(tag);
    load = 1'b0;
    chk({tag, "_pattern"}, pattern, v);
    chk({tag, "_nopulse"}, step_pulse, 1'b0);
    cur = v;
  endtask

  initial begin
    logic [N-1:0] ff;
    int on_cnt;
    rst = 1'b1; en = 1'b0; mode = 2'b00; speed = 2'b00; load = 1'b0;
    load_pattern = '0; brightness = 2'b11; check_led = 1'b0; cur = 8'h01;
    tick(); tick();
    chk("reset_pattern", pattern, 8'h01);
    chk("reset_led", led, 8'h00);
    chk("reset_pulse", step_pulse, 1'b0);

    // ROL then ROR at base speed
    rst = 1'b0; en = 1'b1; check_led = 1'b1;
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(1 << (i % 8)));
    run_steps(8, 4, "rol");
    mode = 2'b01;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h80 >> i));
    run_steps(8, 4, "ror");

    // Speed select
    mode = 2'b00; speed = 2'd1;
    exp_q.push_back(8'h02); exp_q.push_back(8'h04); exp_q.push_back(8'h08);
    run_steps(3, 2, "spd1");
    speed = 2'd2;
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    run_steps(2, 1, "spd2");
    speed = 2'd3;
    exp_q.push_back(8'h40); exp_q.push_back(8'h80); exp_q.push_back(8'h01);
    run_steps(3, 1, "spd3");
    // Shorten period while count is already past the new compare value
    speed = 2'd0;
    tick_led("spdchg"); chk("spdchg_nopulse1", step_pulse, 1'b0);
    tick_led("spdchg"); chk("spdchg_nopulse2", step_pulse, 1'b0);
    speed = 2'd1;
    exp_q.push_back(8'h02);
    run_steps(1, 1, "spdchg");
    speed = 2'd0;

    // Bounce
    mode = 2'b10;
    do_load(8'h01, "bnc_load");
    for (int i = 1; i <= 7; i++) exp_q.push_back(8'(1 << i));
    for (int i = 6; i >= 0; i--) exp_q.push_back(8'(1 << i));
    exp_q.push_back(8'h02);
    run_steps(15, 4, "bnc");
    for (int i = 2; i <= 7; i++) exp_q.push_back(8'(1 << i));
    exp_q.push_back(8'h40);
    run_steps(7, 4, "bnc2");
    mode = 2'b00;
    exp_q.push_back(8'h80); exp_q.push_back(8'h01);
    run_steps(2, 4, "bnc_rol");

    // Fill / drain
    mode = 2'b11;
    do_load(8'h01, "fill_load");
    for (int i = 1; i <= 7; i++) exp_q.push_back(8'((1 << (i + 1)) - 1));
    ff = 8'hFF;
    for (int i = 1; i <= 8; i++) exp_q.push_back(ff << i);
    exp_q.push_back(8'h01);
    run_steps(16, 4, "fill");

    // Load at count 3 discards the coincident step
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick_led("preload");
      chk("preload_nopulse", step_pulse, 1'b0);
    end
    do_load(8'hA5, "load");
    exp_q.push_back(8'h4B);
    run_steps(1, 4, "after_load");

    // Pause freezes count and pattern
    tick_led("pause_pre");
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_led("pause");
      chk("pause_nopulse", step_pulse, 1'b0);
      chk("pause_pattern", pattern, 8'h4B);
    end
    en = 1'b1;
    exp_q.push_back(8'h96);
    run_steps(1, 3, "pause_resume");

    // PWM duty with pattern frozen
    en = 1'b0; check_led = 1'b0;
    brightness = 2'd1; on_cnt = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (led === 8'h96) on_cnt++;
      else chk("pwm1_off_led", led, 8'h00);
    end
    chk("pwm1_on_count", on_cnt, 2);
    brightness = 2'd2; on_cnt = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (led === 8'h96) on_cnt++;
      else chk("pwm2_off_led", led, 8'h00);
    end
    chk("pwm2_on_count", on_cnt, 4);
    brightness = 2'd0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("pwm0_led", led, 8'h00);
    end
    brightness = 2'd3;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("pwm3_led", led, 8'h96);
    end

    // Asynchronous reset mid-count, between clock edges
    en = 1'b1;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pattern", pattern, 8'h01);
    chk("async_rst_led", led, 8'h00);
    chk("async_rst_pulse", step_pulse, 1'b0);
    tick();
    rst = 1'b0; cur = 8'h01; check_led = 1'b1;
    exp_q.push_back(8'h02); exp_q.push_back(8'h04);
    run_steps(2, 4, "post_rst");
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
